spi_master: RTL

SPI mode-0 master that drives `cs`/`sck`/`MOSI` and samples `MISO`. It is the initiator counterpart of the FPGA's SPI slave, used for on-board self-test loopback and for talking to external SPI peripherals. It runs from the fabric clock. Bytes are supplied through a valid/ready handshake, and a `tx_last` flag ends the chip-select frame. Received bytes come back with a one-cycle strobe.

---
 rtl/spi_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: valid/ready byte input, tx_last closes the chip-select frame,
// and each received byte is returned with a one-cycle strobe.
module spi_master #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic [7:0] rxd_out_o,
  output logic       rxd_flag_o,
  output logic       busy_o,
  output logic       cs_o,
  output logic       sck_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int unsigned DivW     = $clog2(CLK_DIV);
  localparam int unsigned GuardMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned GuardW   = $clog2(GuardMax + 1);

  localparam logic [DivW-1:0]   DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [GuardW-1:0] SetupLast = GuardW'(CS_SETUP - 1);
  localparam logic [GuardW-1:0] HoldLast  = GuardW'(CS_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StNext, StHold} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic              last_q, last_d;
  logic              tx_ready_q, tx_ready_d;
  logic [7:0]        rxd_q, rxd_d;
  logic              rxd_flag_q, rxd_flag_d;
  logic              cs_q, cs_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              miso_meta_q, miso_sync_q;
  logic              accept;

  assign accept = tx_valid_i & tx_ready_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    guard_d    = guard_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    last_d     = last_q;
    rxd_d      = rxd_q;
    rxd_flag_d = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      StIdle: begin
        cs_d  = 1'b1;
        sck_d = 1'b0;
        if (accept) begin
          state_d = StSetup;
          cs_d    = 1'b0;
          mosi_d  = tx_data_i[7];
          tx_d    = tx_data_i[6:0];
          last_d  = tx_last_i;
          guard_d = '0;
        end
      end
      StSetup: begin
        if (guard_q == SetupLast) begin
          state_d   = StShift;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
      StShift: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: sample MISO late in the high phase, then advance MOSI.
            sck_d     = 1'b0;
            rx_d      = {rx_q[5:0], miso_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rxd_d      = {rx_q, miso_sync_q};
              rxd_flag_d = 1'b1;
              guard_d    = '0;
              state_d    = last_q ? StHold : StNext;
            end else begin
              mosi_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DivW'(1);
        end
      end
      StNext: begin
        cs_d  = 1'b0;
        sck_d = 1'b0;
        if (accept) begin
          state_d   = StShift;
          mosi_d    = tx_data_i[7];
          tx_d      = tx_data_i[6:0];
          last_d    = tx_last_i;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      StHold: begin
        if (guard_q == HoldLast) begin
          state_d = StIdle;
          cs_d    = 1'b1;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    tx_ready_d = (state_d == StIdle) || (state_d == StNext);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      div_cnt_q   <= '0;
      guard_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      rxd_q       <= 8'h00;
      rxd_flag_q  <= 1'b0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      guard_q     <= guard_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      tx_ready_q  <= tx_ready_d;
      rxd_q       <= rxd_d;
      rxd_flag_q  <= rxd_flag_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      miso_meta_q <= miso_i;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rxd_out_o  = rxd_q;
  assign rxd_flag_o = rxd_flag_q;
  assign busy_o     = (state_q != StIdle);
  assign cs_o       = cs_q;
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;

endmodule
